// File: rtl/minisys_defs_pkg.sv
// MiniSys shared definitions: widths, bubble encoding,
// PC-select polarity and the M-stage control bundle.
package minisys_defs;

  localparam int DW = 32;
  localparam int RW = 5;

  localparam logic PCSRC_SEQ = 1'b1;
  localparam logic PCSRC_BR  = 1'b0;

  localparam logic [DW-1:0] NOP_WORD = '0;

  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } br_state_t;

  typedef struct packed {
    logic          valid;
    logic          branch;
    logic          bne;
    logic          zero;
    logic          regwrite;
    logic          memwrite;
    logic          memtoreg;
    logic [RW-1:0] writereg;
  } m_ctl_t;

  localparam m_ctl_t CTL_BUBBLE = '0;

endpackage

// File: rtl/dffe_32.sv
// 32-bit register with load enable, synchronous clear
// and asynchronous active-low reset.
module dffe_32 (
  input  logic        clk,
  input  logic        clrn,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/minisys_branch_resolve.sv
// EX->MEM pipeline register with branch resolution in MEM,
// PC redirect, wrong-path squash and branch counters.
module minisys_branch_resolve
  import minisys_defs::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             enM,
  input  logic             cnt_clr,
  input  logic             validE,
  input  logic             branchE,
  input  logic             bneE,
  input  logic             zeroE,
  input  logic [31:0]      pcbranchE,
  input  logic [31:0]      aluoutE,
  input  logic [31:0]      writedataE,
  input  logic [4:0]       writeregE,
  input  logic             regwriteE,
  input  logic             memwriteE,
  input  logic             memtoregE,
  output logic             pc_srcM,
  output logic [31:0]      pcbranchM,
  output logic [31:0]      aluoutM,
  output logic [31:0]      writedataM,
  output logic [4:0]       writeregM,
  output logic             regwriteM,
  output logic             memwriteM,
  output logic             memtoregM,
  output logic             flushD,
  output logic             flushE,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  br_state_t        r_state;
  br_state_t        w_next;
  m_ctl_t           r_ctl;
  m_ctl_t           w_ctlE;
  logic             w_taken;
  logic             w_squash;
  logic             w_brev;
  logic [CNT_W-1:0] r_bcnt;
  logic [CNT_W-1:0] r_tcnt;

  assign w_ctlE = '{
    valid:    validE,
    branch:   branchE,
    bne:      bneE,
    zero:     zeroE,
    regwrite: regwriteE,
    memwrite: memwriteE,
    memtoreg: memtoregE,
    writereg: writeregE
  };

  // Resolved purely from registered M state: no E->output path.
  assign w_taken = r_ctl.valid & r_ctl.branch
                 & (r_ctl.zero ^ r_ctl.bne)
                 & (r_state == RUN);
  assign w_squash = enM & w_taken;
  assign w_brev   = enM & r_ctl.valid & r_ctl.branch;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      r_ctl <= CTL_BUBBLE;
    else if (enM)
      r_ctl <= w_squash ? CTL_BUBBLE : w_ctlE;
  end

  dffe_32 u_pcbranch (
    .clk  (clk),
    .clrn (clrn),
    .en   (enM),
    .clr  (w_squash),
    .d    (pcbranchE),
    .q    (pcbranchM)
  );

  dffe_32 u_aluout (
    .clk  (clk),
    .clrn (clrn),
    .en   (enM),
    .clr  (w_squash),
    .d    (aluoutE),
    .q    (aluoutM)
  );

  dffe_32 u_wdata (
    .clk  (clk),
    .clrn (clrn),
    .en   (enM),
    .clr  (w_squash),
    .d    (writedataE),
    .q    (writedataM)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      r_state <= RUN;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RUN:   if (w_squash) w_next = REDIR;
      REDIR: if (enM)      w_next = RUN;
      default:             w_next = RUN;
    endcase
  end

  // Counters saturate; clear wins over a same-cycle event.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_bcnt <= '0;
      r_tcnt <= '0;
    end else if (cnt_clr) begin
      r_bcnt <= '0;
      r_tcnt <= '0;
    end else if (w_brev) begin
      if (r_bcnt != '1)
        r_bcnt <= r_bcnt + CNT_W'(1);
      if (w_taken && r_tcnt != '1)
        r_tcnt <= r_tcnt + CNT_W'(1);
    end
  end

  assign pc_srcM    = w_taken ? PCSRC_BR : PCSRC_SEQ;
  assign flushD     = w_taken;
  assign flushE     = w_taken;
  assign writeregM  = r_ctl.writereg;
  assign regwriteM  = r_ctl.regwrite;
  assign memwriteM  = r_ctl.memwrite;
  assign memtoregM  = r_ctl.memtoreg;
  assign branch_cnt = r_bcnt;
  assign taken_cnt  = r_tcnt;

endmodule

// File: tb/tb_minisys_branch_resolve.sv
// Directed self-checking bench for minisys_branch_resolve.
module tb_minisys_branch_resolve;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          clrn;
  logic          enM;
  logic          cnt_clr;
  logic          validE;
  logic          branchE;
  logic          bneE;
  logic          zeroE;
  logic [31:0]   pcbranchE;
  logic [31:0]   aluoutE;
  logic [31:0]   writedataE;
  logic [4:0]    writeregE;
  logic          regwriteE;
  logic          memwriteE;
  logic          memtoregE;
  logic          pc_srcM;
  logic [31:0]   pcbranchM;
  logic [31:0]   aluoutM;
  logic [31:0]   writedataM;
  logic [4:0]    writeregM;
  logic          regwriteM;
  logic          memwriteM;
  logic          memtoregM;
  logic          flushD;
  logic          flushE;
  logic [CW-1:0] branch_cnt;
  logic [CW-1:0] taken_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  minisys_branch_resolve #(.CNT_W(CW)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .enM        (enM),
    .cnt_clr    (cnt_clr),
    .validE     (validE),
    .branchE    (branchE),
    .bneE       (bneE),
    .zeroE      (zeroE),
    .pcbranchE  (pcbranchE),
    .aluoutE    (aluoutE),
    .writedataE (writedataE),
    .writeregE  (writeregE),
    .regwriteE  (regwriteE),
    .memwriteE  (memwriteE),
    .memtoregE  (memtoregE),
    .pc_srcM    (pc_srcM),
    .pcbranchM  (pcbranchM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .writeregM  (writeregM),
    .regwriteM  (regwriteM),
    .memwriteM  (memwriteM),
    .memtoregM  (memtoregM),
    .flushD     (flushD),
    .flushE     (flushE),
    .branch_cnt (branch_cnt),
    .taken_cnt  (taken_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    validE     = 1'b0;
    branchE    = 1'b0;
    bneE       = 1'b0;
    zeroE      = 1'b0;
    pcbranchE  = '0;
    aluoutE    = '0;
    writedataE = '0;
    writeregE  = '0;
    regwriteE  = 1'b0;
    memwriteE  = 1'b0;
    memtoregE  = 1'b0;
  endtask

  task automatic drive_br(input logic bne, input logic zero,
                          input logic [31:0] tgt);
    drive_idle();
    validE    = 1'b1;
    branchE   = 1'b1;
    bneE      = bne;
    zeroE     = zero;
    pcbranchE = tgt;
  endtask

  task automatic clear_cnt();
    drive_idle();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    step();
  endtask

  task automatic test_reset();
    clrn    = 1'b0;
    enM     = 1'b1;
    cnt_clr = 1'b0;
    validE     = 1'b1;
    branchE    = 1'b1;
    bneE       = 1'($urandom);
    zeroE      = ~bneE;
    pcbranchE  = $urandom;
    aluoutE    = $urandom;
    writedataE = $urandom;
    writeregE  = 5'($urandom);
    regwriteE  = 1'b1;
    memwriteE  = 1'b1;
    memtoregE  = 1'b1;
    repeat (3) step();
    checks++;
    if (pc_srcM !== 1'b1) begin
      errors++;
      $display("FAIL rst_pcsrc got %b exp 1", pc_srcM);
    end
    checks++;
    if ({flushD, flushE} !== 2'b00) begin
      errors++;
      $display("FAIL rst_flush got %b%b exp 00", flushD, flushE);
    end
    checks++;
    if (regwriteM !== 1'b0 || memwriteM !== 1'b0) begin
      errors++;
      $display("FAIL rst_we got %b%b exp 00", regwriteM, memwriteM);
    end
    checks++;
    if (branch_cnt !== '0 || taken_cnt !== '0) begin
      errors++;
      $display("FAIL rst_cnt got %h/%h exp 0/0", branch_cnt, taken_cnt);
    end
    checks++;
    if (pcbranchM !== 32'h0 || aluoutM !== 32'h0) begin
      errors++;
      $display("FAIL rst_data got %h/%h exp 0/0", pcbranchM, aluoutM);
    end
    drive_idle();
    clrn = 1'b1;
    step();
  endtask

  task automatic test_beq_taken();
    clear_cnt();
    drive_br(1'b0, 1'b1, 32'h0000_0040);
    step();
    checks++;
    if (pc_srcM !== 1'b0) begin
      errors++;
      $display("FAIL beq_pcsrc got %b exp 0", pc_srcM);
    end
    checks++;
    if (pcbranchM !== 32'h40) begin
      errors++;
      $display("FAIL beq_target got %h exp 00000040", pcbranchM);
    end
    checks++;
    if ({flushD, flushE} !== 2'b11) begin
      errors++;
      $display("FAIL beq_flush got %b%b exp 11", flushD, flushE);
    end
    drive_idle();
    validE    = 1'b1;
    aluoutE   = 32'hDEAD_BEEF;
    writeregE = 5'd7;
    regwriteE = 1'b1;
    memwriteE = 1'b1;
    step();
    checks++;
    if (regwriteM !== 1'b0 || memwriteM !== 1'b0 || aluoutM !== 32'h0) begin
      errors++;
      $display("FAIL beq_squash got rw%b mw%b alu%h exp 0 0 0",
               regwriteM, memwriteM, aluoutM);
    end
    checks++;
    if (pc_srcM !== 1'b1 || flushD !== 1'b0) begin
      errors++;
      $display("FAIL beq_after got pc%b fl%b exp 1 0", pc_srcM, flushD);
    end
    checks++;
    if (branch_cnt !== 4'd1 || taken_cnt !== 4'd1) begin
      errors++;
      $display("FAIL beq_cnt got %0d/%0d exp 1/1", branch_cnt, taken_cnt);
    end
    drive_idle();
    step();
  endtask

  task automatic test_bne_not_taken();
    clear_cnt();
    drive_br(1'b1, 1'b1, 32'h0000_0100);
    step();
    checks++;
    if (pc_srcM !== 1'b1 || {flushD, flushE} !== 2'b00) begin
      errors++;
      $display("FAIL bne_nt got pc%b fl%b%b exp 1 00", pc_srcM, flushD, flushE);
    end
    drive_idle();
    validE     = 1'b1;
    aluoutE    = 32'h0000_1234;
    writedataE = 32'hA5A5_0001;
    writeregE  = 5'd5;
    regwriteE  = 1'b1;
    memtoregE  = 1'b1;
    step();
    checks++;
    if (aluoutM !== 32'h1234 || writeregM !== 5'd5 || regwriteM !== 1'b1) begin
      errors++;
      $display("FAIL bne_alu got %h r%0d w%b exp 00001234 r5 w1",
               aluoutM, writeregM, regwriteM);
    end
    checks++;
    if (writedataM !== 32'hA5A5_0001 || memtoregM !== 1'b1
        || memwriteM !== 1'b0) begin
      errors++;
      $display("FAIL bne_mem got %h t%b m%b exp a5a50001 1 0",
               writedataM, memtoregM, memwriteM);
    end
    checks++;
    if (branch_cnt !== 4'd1 || taken_cnt !== 4'd0) begin
      errors++;
      $display("FAIL bne_cnt got %0d/%0d exp 1/0", branch_cnt, taken_cnt);
    end
    drive_idle();
    step();
  endtask

  task automatic test_stall_redirect();
    clear_cnt();
    drive_br(1'b0, 1'b1, 32'h0000_0200);
    step();
    drive_br(1'b0, 1'b1, 32'h0000_0300);
    enM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pc_srcM !== 1'b0 || {flushD, flushE} !== 2'b11
          || pcbranchM !== 32'h200) begin
        errors++;
        $display("FAIL stall_hold%0d got pc%b fl%b%b t%h exp 0 11 00000200",
                 i, pc_srcM, flushD, flushE, pcbranchM);
      end
      checks++;
      if (branch_cnt !== 4'd0 || taken_cnt !== 4'd0) begin
        errors++;
        $display("FAIL stall_cnt%0d got %0d/%0d exp 0/0",
                 i, branch_cnt, taken_cnt);
      end
    end
    enM = 1'b1;
    step();
    checks++;
    if (pc_srcM !== 1'b1 || flushD !== 1'b0 || pcbranchM !== 32'h0) begin
      errors++;
      $display("FAIL stall_release got pc%b fl%b t%h exp 1 0 0",
               pc_srcM, flushD, pcbranchM);
    end
    checks++;
    if (branch_cnt !== 4'd1 || taken_cnt !== 4'd1) begin
      errors++;
      $display("FAIL stall_cnt_end got %0d/%0d exp 1/1", branch_cnt, taken_cnt);
    end
    drive_idle();
    step();
  endtask

  task automatic test_back_to_back();
    clear_cnt();
    drive_br(1'b0, 1'b1, 32'h0000_0040);
    step();
    checks++;
    if (pc_srcM !== 1'b0 || pcbranchM !== 32'h40) begin
      errors++;
      $display("FAIL b2b_first got pc%b t%h exp 0 00000040", pc_srcM, pcbranchM);
    end
    drive_br(1'b1, 1'b0, 32'h0000_0080);
    step();
    checks++;
    if (pc_srcM !== 1'b1 || pcbranchM === 32'h80) begin
      errors++;
      $display("FAIL b2b_second got pc%b t%h exp 1 not-00000080",
               pc_srcM, pcbranchM);
    end
    drive_idle();
    step();
    checks++;
    if (pc_srcM !== 1'b1 || branch_cnt !== 4'd1 || taken_cnt !== 4'd1) begin
      errors++;
      $display("FAIL b2b_cnt got pc%b %0d/%0d exp 1 1/1",
               pc_srcM, branch_cnt, taken_cnt);
    end
    step();
  endtask

  task automatic test_saturate_clear();
    clear_cnt();
    for (int i = 0; i < 17; i++) begin
      drive_br(1'b0, 1'b1, 32'h1000 + 32'(i));
      step();
      drive_idle();
      step();
    end
    checks++;
    if (branch_cnt !== 4'hF || taken_cnt !== 4'hF) begin
      errors++;
      $display("FAIL sat_cnt got %h/%h exp f/f", branch_cnt, taken_cnt);
    end
    drive_br(1'b0, 1'b1, 32'h0000_0500);
    step();
    drive_idle();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++;
    if (branch_cnt !== 4'h0 || taken_cnt !== 4'h0) begin
      errors++;
      $display("FAIL clr_cnt got %h/%h exp 0/0", branch_cnt, taken_cnt);
    end
    step();
  endtask

  task automatic test_reset_mid_redirect();
    drive_br(1'b0, 1'b1, 32'h0000_0600);
    step();
    checks++;
    if (pc_srcM !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre got %b exp 0", pc_srcM);
    end
    drive_idle();
    clrn = 1'b0;
    #1;
    checks++;
    if (pc_srcM !== 1'b1 || {flushD, flushE} !== 2'b00
        || pcbranchM !== 32'h0) begin
      errors++;
      $display("FAIL mid_rst got pc%b fl%b%b t%h exp 1 00 0",
               pc_srcM, flushD, flushE, pcbranchM);
    end
    step();
    clrn = 1'b1;
    step();
    checks++;
    if (pc_srcM !== 1'b1 || flushD !== 1'b0) begin
      errors++;
      $display("FAIL mid_after got pc%b fl%b exp 1 0", pc_srcM, flushD);
    end
  endtask

  initial begin
    drive_idle();
    clrn    = 1'b0;
    enM     = 1'b1;
    cnt_clr = 1'b0;
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_stall_redirect();
    test_back_to_back();
    test_saturate_clear();
    test_reset_mid_redirect();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
